// File: rtl/pipe_stage_buf_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipeline stage buffer.
//   HOLD_CNT_W  : width of the flush squash-window counter (FLUSH_HOLD <= 15)
//   pipe_slot_t : one buffer slot (valid, control vector, data payload) at the
//                 core's default stage widths; stage instances with other
//                 widths declare a slot type of the same field layout.
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int HOLD_CNT_W = 4;
   localparam int DEF_CTRL_W = 16;
   localparam int DEF_DATA_W = 128;

   typedef struct packed {
      logic                  valid;
      logic [DEF_CTRL_W-1:0] ctrl;
      logic [DEF_DATA_W-1:0] data;
   } pipe_slot_t;

endpackage

// File: rtl/pipe_stage_buf_chk.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf_chk
// Structural invariants of the stage buffer.
//   clk, rst  : clock and asynchronous active-high reset
//   h_valid   : head slot valid
//   s_valid   : skid slot valid
//   out_valid : head entry valid as seen downstream
//   out_ctrl  : head control vector
// -----------------------------------------------------------------------------
module pipe_stage_buf_chk #(
   parameter int CTRL_W = 16
) (
   input logic              clk,
   input logic              rst,
   input logic              h_valid,
   input logic              s_valid,
   input logic              out_valid,
   input logic [CTRL_W-1:0] out_ctrl
);

   // The skid slot is only ever filled behind an occupied head.
   skid_implies_head : assert property (@(posedge clk) disable iff (rst)
      s_valid |-> h_valid);

   // An empty head never presents a live control vector downstream.
   idle_ctrl_zero : assert property (@(posedge clk) disable iff (rst)
      !out_valid |-> (out_ctrl == '0));

endmodule

// File: rtl/pipe_stage_buf_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One storage slot of the stage buffer: a clearable, loadable register.
//   clk, rst : clock and asynchronous active-high reset (clears the slot)
//   clr      : synchronous clear to all-zero (wins over ld)
//   ld       : load d on the next rising edge
//   d, q     : slot contents in / out (type given by parameter slot_t)
// -----------------------------------------------------------------------------
module pipe_slot
   import pipe_pkg::*;
#(
   parameter type slot_t = pipe_slot_t
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  clr,
   input  logic  ld,
   input  slot_t d,
   output slot_t q
);

   slot_t slot_q;
   slot_t slot_d;

   // Next slot value: clear has priority over load.
   always_comb begin
      slot_d = slot_q;
      if (clr) begin
         slot_d = '0;
      end else if (ld) begin
         slot_d = d;
      end else begin
         slot_d = slot_q;
      end
   end

   // Slot register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign q = slot_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
// Parametrised pipeline stage register with valid/ready handshake, a 2-entry
// skid buffer (head H drives the outputs, skid S catches the in-flight entry),
// an external stall and a flush that squashes the stage for FLUSH_HOLD edges.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : upstream handshake (in_ready is registered)
//   in_ctrl, in_data      : upstream control vector and payload
//   stall                 : hold the head entry, nothing leaves the stage
//   flush                 : squash request, opens the hold window
//   out_valid/out_ready   : downstream handshake
//   out_ctrl, out_data    : head control vector (zero when idle) and payload
//   flush_busy            : squash window still active
//   occupancy             : number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int CTRL_W     = 16,
   parameter int DATA_W     = 128,
   parameter int CLEAR_DATA = 1,
   parameter int FLUSH_HOLD = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic              flush_busy,
   output logic [1:0]        occupancy
);

   typedef struct packed {
      logic              valid;
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } stage_slot_t;

   localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(FLUSH_HOLD - 1);

   // A slot that gives up its entry: control is always zeroed, data only when
   // CLEAR_DATA is set (otherwise the stale payload is kept to save toggling).
   function automatic stage_slot_t vacate(input stage_slot_t s);
      stage_slot_t r;
      r.valid = 1'b0;
      r.ctrl  = '0;
      if (CLEAR_DATA != 0) begin
         r.data = '0;
      end else begin
         r.data = s.data;
      end
      return r;
   endfunction

   stage_slot_t            h_q, h_d, s_q, s_d, in_slot;
   logic                   h_ld, s_ld, slot_clr;
   logic                   push, pop, squash;
   logic [HOLD_CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic                   in_ready_q, in_ready_d;
   logic                   flush_busy_q, flush_busy_d;
   logic [1:0]             occupancy_q, occupancy_d;

   // Handshake decode, hold window counter and slot next-state.
   always_comb begin
      push          = in_valid & in_ready_q;
      pop           = h_q.valid & out_ready & ~stall;
      squash        = flush | (hold_cnt_q != '0);
      in_slot.valid = 1'b1;
      in_slot.ctrl  = in_ctrl;
      in_slot.data  = in_data;
      h_d           = h_q;
      s_d           = s_q;
      h_ld          = 1'b0;
      s_ld          = 1'b0;

      // A new flush (also inside the window) reloads the counter.
      if (flush) begin
         hold_cnt_d = HOLD_LOAD;
      end else if (hold_cnt_q != '0) begin
         hold_cnt_d = hold_cnt_q - HOLD_CNT_W'(1);
      end else begin
         hold_cnt_d = hold_cnt_q;
      end

      if (squash) begin
         // Anything accepted on a squash edge is dropped with the stage.
         h_d  = vacate(h_q);
         s_d  = vacate(s_q);
         h_ld = 1'b1;
         s_ld = 1'b1;
      end else if (!h_q.valid) begin
         // Empty stage: S is necessarily empty, a push lands in H.
         h_d  = push ? in_slot : h_q;
         h_ld = push;
      end else if (pop) begin
         h_ld = 1'b1;
         if (s_q.valid) begin
            h_d  = s_q;
            s_d  = push ? in_slot : vacate(s_q);
            s_ld = 1'b1;
         end else begin
            h_d  = push ? in_slot : vacate(h_q);
         end
      end else begin
         // Head blocked: an accepted entry is caught by the skid slot.
         s_d  = push ? in_slot : s_q;
         s_ld = push;
      end

      slot_clr     = squash & (CLEAR_DATA != 0);
      in_ready_d   = ~s_d.valid & (hold_cnt_d == '0);
      flush_busy_d = (hold_cnt_d != '0);
      occupancy_d  = {1'b0, h_d.valid} + {1'b0, s_d.valid};
   end

   // Control registers: hold counter and the registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt_q   <= '0;
         in_ready_q   <= 1'b1;
         flush_busy_q <= 1'b0;
         occupancy_q  <= 2'd0;
      end else begin
         hold_cnt_q   <= hold_cnt_d;
         in_ready_q   <= in_ready_d;
         flush_busy_q <= flush_busy_d;
         occupancy_q  <= occupancy_d;
      end
   end

   pipe_slot #(.slot_t(stage_slot_t)) u_head (
      .clk (clk),
      .rst (rst),
      .clr (slot_clr),
      .ld  (h_ld),
      .d   (h_d),
      .q   (h_q)
   );

   pipe_slot #(.slot_t(stage_slot_t)) u_skid (
      .clk (clk),
      .rst (rst),
      .clr (slot_clr),
      .ld  (s_ld),
      .d   (s_d),
      .q   (s_q)
   );

   pipe_stage_buf_chk #(.CTRL_W(CTRL_W)) u_chk (
      .clk       (clk),
      .rst       (rst),
      .h_valid   (h_q.valid),
      .s_valid   (s_q.valid),
      .out_valid (h_q.valid),
      .out_ctrl  (h_q.ctrl)
   );

   assign out_valid  = h_q.valid;
   assign out_ctrl   = h_q.ctrl;
   assign out_data   = h_q.data;
   assign in_ready   = in_ready_q;
   assign flush_busy = flush_busy_q;
   assign occupancy  = occupancy_q;

endmodule
